// File: rtl/dino_sprite_renderer.sv
// rtl/dino_sprite_renderer.sv - 3-stage sprite overlay on a VGA pixel stream
// Position updates are double-buffered and only take effect at frame end.
module dino_sprite_renderer #(
   parameter int          SPR_W     = 32,
   parameter int          SPR_H     = 32,
   parameter logic [11:0] BG_COLOR  = 12'hFFF,
   parameter logic [11:0] KEY_COLOR = 12'h0F0,
   parameter int          DEF_X     = 64,
   parameter int          DEF_Y     = 400,
   localparam int         AW        = $clog2(SPR_W * SPR_H)
) (
   input  logic          clk25,
   input  logic          resetn,
   input  logic          active,
   input  logic          screenEnd,
   input  logic          hSync,
   input  logic          vSync,
   input  logic [9:0]    x,
   input  logic [8:0]    y,
   input  logic          pos_valid,
   input  logic [9:0]    pos_x,
   input  logic [8:0]    pos_y,
   output logic          pos_ready,
   output logic [AW-1:0] rom_addr,
   input  logic [11:0]   rom_data,
   output logic [3:0]    VGA_R,
   output logic [3:0]    VGA_G,
   output logic [3:0]    VGA_B,
   output logic          hSync_out,
   output logic          vSync_out,
   output logic [15:0]   frame_count
);

   logic [9:0]    r_live_x, r_pend_x;
   logic [8:0]    r_live_y, r_pend_y;
   logic          r_pend_full;
   logic          r_hit1, r_hit2;
   logic          r_act1, r_act2;
   logic [2:0]    r_hs, r_vs;
   logic [11:0]   r_rgb;
   logic [AW-1:0] r_rom_addr;
   logic [15:0]   r_frames;

   logic          w_accept, w_hit;
   logic [10:0]   w_x, w_y, w_lx, w_ly, w_dx, w_dy;
   logic [AW-1:0] w_addr;
   logic [11:0]   w_rgb;

   // 11-bit compare so a sprite near the right/bottom edge is clipped, not wrapped
   assign w_x    = {1'b0, x};
   assign w_y    = {2'b00, y};
   assign w_lx   = {1'b0, r_live_x};
   assign w_ly   = {2'b00, r_live_y};
   assign w_hit  = (w_x >= w_lx) && (w_x < w_lx + 11'(SPR_W)) &&
                   (w_y >= w_ly) && (w_y < w_ly + 11'(SPR_H));
   assign w_dx   = w_x - w_lx;
   assign w_dy   = w_y - w_ly;
   assign w_addr = AW'(w_dy) * AW'(SPR_W) + AW'(w_dx);

   assign pos_ready = ~r_pend_full;
   assign w_accept  = pos_valid & ~r_pend_full;

   always_ff @(posedge clk25 or negedge resetn) begin
      if (!resetn) begin
         r_live_x    <= 10'(DEF_X);
         r_live_y    <= 9'(DEF_Y);
         r_pend_x    <= '0;
         r_pend_y    <= '0;
         r_pend_full <= 1'b0;
      end else if (screenEnd && r_pend_full) begin
         r_live_x    <= r_pend_x;
         r_live_y    <= r_pend_y;
         r_pend_full <= 1'b0;
      end else if (w_accept) begin
         r_pend_x    <= pos_x;
         r_pend_y    <= pos_y;
         r_pend_full <= 1'b1;
      end
   end

   always_ff @(posedge clk25 or negedge resetn) begin
      if (!resetn) begin
         r_frames <= '0;
      end else if (screenEnd) begin
         r_frames <= r_frames + 16'd1;
      end
   end

   always_ff @(posedge clk25 or negedge resetn) begin
      if (!resetn) begin
         r_hit1     <= 1'b0;
         r_hit2     <= 1'b0;
         r_act1     <= 1'b0;
         r_act2     <= 1'b0;
         r_hs       <= 3'b111;
         r_vs       <= 3'b111;
         r_rgb      <= '0;
         r_rom_addr <= '0;
      end else begin
         r_hit1     <= w_hit;
         r_hit2     <= r_hit1;
         r_act1     <= active;
         r_act2     <= r_act1;
         r_hs       <= {r_hs[1:0], hSync};
         r_vs       <= {r_vs[1:0], vSync};
         r_rgb      <= w_rgb;
         r_rom_addr <= w_hit ? w_addr : '0;
      end
   end

   // rom_data here belongs to the pixel whose hit flag is now in r_hit2
   always_comb begin
      w_rgb = BG_COLOR;
      if (!r_act2) begin
         w_rgb = 12'h000;
      end else if (r_hit2 && (rom_data != KEY_COLOR)) begin
         w_rgb = rom_data;
      end
   end

   assign rom_addr    = r_rom_addr;
   assign VGA_R       = r_rgb[11:8];
   assign VGA_G       = r_rgb[7:4];
   assign VGA_B       = r_rgb[3:0];
   assign hSync_out   = r_hs[2];
   assign vSync_out   = r_vs[2];
   assign frame_count = r_frames;

endmodule

// File: tb/tb_dino_sprite_renderer.sv
// tb/tb_dino_sprite_renderer.sv - directed and randomized checks against a pixel-level reference model
module tb_dino_sprite_renderer;

   localparam int          SW  = 32;
   localparam int          SH  = 32;
   localparam logic [11:0] BG  = 12'hFFF;
   localparam logic [11:0] KEY = 12'h0F0;

   logic        clk25, resetn, active, screenEnd, hSync, vSync;
   logic [9:0]  x, pos_x;
   logic [8:0]  y, pos_y;
   logic        pos_valid, pos_ready;
   logic [9:0]  rom_addr;
   logic [11:0] rom_data;
   logic [3:0]  VGA_R, VGA_G, VGA_B;
   logic        hSync_out, vSync_out;
   logic [15:0] frame_count;

   dino_sprite_renderer dut (
      .clk25(clk25), .resetn(resetn), .active(active), .screenEnd(screenEnd),
      .hSync(hSync), .vSync(vSync), .x(x), .y(y),
      .pos_valid(pos_valid), .pos_x(pos_x), .pos_y(pos_y), .pos_ready(pos_ready),
      .rom_addr(rom_addr), .rom_data(rom_data),
      .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
      .hSync_out(hSync_out), .vSync_out(vSync_out), .frame_count(frame_count)
   );

   initial clk25 = 1'b0;
   always #20 clk25 = ~clk25;

   logic [11:0] rom_mem [0:1023];
   always @(posedge clk25) rom_data <= rom_mem[rom_addr];

   int n_cmp = 0;
   int n_err = 0;

   int m_lx, m_ly, m_px, m_py, m_frames;
   bit m_pf;
   logic [13:0] exp_q [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic bit model_hit(input int px, input int py);
      return (px >= m_lx) && (px < m_lx + SW) && (py >= m_ly) && (py < m_ly + SH);
   endfunction

   function automatic logic [11:0] model_rgb(input int px, input int py, input bit act);
      int a;
      if (!act) return 12'h000;
      if (!model_hit(px, py)) return BG;
      a = (py - m_ly) * SW + (px - m_lx);
      if (rom_mem[a] == KEY) return BG;
      return rom_mem[a];
   endfunction

   task automatic model_reset();
      m_lx = 64; m_ly = 400; m_pf = 0; m_px = 0; m_py = 0; m_frames = 0;
      exp_q.delete();
   endtask

   // One pixel clock: drive at negedge, predict, then check after the next posedge
   task automatic cyc(input int px, input int py, input bit act, input bit hs, input bit vs,
                      input bit se, input bit pv, input int nx, input int ny);
      logic [13:0] e;
      int ea;
      x = px[9:0]; y = py[8:0]; active = act; hSync = hs; vSync = vs;
      screenEnd = se; pos_valid = pv; pos_x = nx[9:0]; pos_y = ny[8:0];
      ea = model_hit(px, py) ? (py - m_ly) * SW + (px - m_lx) : 0;
      e = {model_rgb(px, py, act), hs, vs};
      exp_q.push_back(e);
      if (se && m_pf) begin
         m_lx = m_px; m_ly = m_py; m_pf = 0;
      end else if (pv && !m_pf) begin
         m_px = nx; m_py = ny; m_pf = 1;
      end
      if (se) m_frames = (m_frames + 1) % 65536;
      @(posedge clk25);
      @(negedge clk25);
      chk("rom_addr", rom_addr, ea);
      chk("pos_ready", pos_ready, !m_pf);
      chk("frame_count", frame_count, m_frames);
      if (exp_q.size() == 3) begin
         e = exp_q.pop_front();
         chk("pixel", {VGA_R, VGA_G, VGA_B, hSync_out, vSync_out}, e);
      end
   endtask

   task automatic idle();
      cyc(0, 0, 0, 1, 1, 0, 0, 0, 0);
   endtask

   initial begin
      int rx, ry;
      bit ract, rse, rpv;
      for (int i = 0; i < 1024; i++)
         rom_mem[i] = ($urandom_range(0, 7) == 0) ? KEY : 12'($urandom);
      rom_mem[0]    = 12'hF00;
      rom_mem[5]    = KEY;
      rom_mem[19]   = 12'h456;
      rom_mem[33]   = 12'h789;
      rom_mem[1023] = 12'h123;

      resetn = 1'b0; active = 0; screenEnd = 0; hSync = 1; vSync = 1;
      x = 0; y = 0; pos_valid = 0; pos_x = 0; pos_y = 0;
      model_reset();
      repeat (3) @(negedge clk25);
      chk("rst_rgb", {VGA_R, VGA_G, VGA_B}, 12'h000);
      chk("rst_hs", hSync_out, 1);
      chk("rst_vs", vSync_out, 1);
      chk("rst_rom_addr", rom_addr, 0);
      chk("rst_pos_ready", pos_ready, 1);
      chk("rst_frames", frame_count, 0);
      resetn = 1'b1;

      // First sprite pixel appears exactly three cycles later
      cyc(64, 400, 1, 1, 1, 0, 0, 0, 0);
      chk("first_addr", rom_addr, 0);
      idle();
      chk("latency_not_yet", {VGA_R, VGA_G, VGA_B}, 12'h000);
      idle();
      chk("first_rgb", {VGA_R, VGA_G, VGA_B}, 12'hF00);

      // Last pixel, right-edge miss, key colour
      cyc(95, 431, 1, 1, 1, 0, 0, 0, 0);
      chk("last_addr", rom_addr, 1023);
      cyc(96, 431, 1, 1, 1, 0, 0, 0, 0);
      chk("edge_miss_addr", rom_addr, 0);
      cyc(69, 400, 1, 1, 1, 0, 0, 0, 0);
      chk("last_rgb", {VGA_R, VGA_G, VGA_B}, 12'h123);
      idle();
      chk("edge_miss_rgb", {VGA_R, VGA_G, VGA_B}, BG);
      idle();
      chk("key_rgb", {VGA_R, VGA_G, VGA_B}, BG);

      // Mid-frame offer waits for screenEnd
      cyc(630, 10, 1, 1, 1, 0, 1, 620, 10);
      chk("offer_ready_low", pos_ready, 0);
      cyc(639, 10, 1, 1, 1, 0, 0, 0, 0);
      chk("live_unchanged", rom_addr, 0);
      cyc(0, 0, 0, 1, 1, 1, 0, 0, 0);
      chk("commit_ready", pos_ready, 1);
      cyc(639, 10, 1, 1, 1, 0, 0, 0, 0);
      chk("clip_addr", rom_addr, 19);
      cyc(0, 10, 1, 1, 1, 0, 0, 0, 0);
      chk("x0_miss", rom_addr, 0);

      // Offer coinciding with screenEnd; a second offer while full is refused
      cyc(0, 0, 0, 1, 1, 1, 1, 100, 100);
      chk("se_offer_pending", pos_ready, 0);
      cyc(100, 100, 1, 1, 1, 0, 0, 0, 0);
      chk("se_offer_no_commit", rom_addr, 0);
      cyc(0, 0, 0, 1, 1, 0, 1, 200, 200);
      chk("full_refuse", pos_ready, 0);
      cyc(0, 0, 0, 1, 1, 1, 0, 0, 0);
      cyc(101, 101, 1, 1, 1, 0, 0, 0, 0);
      chk("next_frame_commit", rom_addr, 33);

      // Sync delay with active low
      cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 1, 0, 0, 0, 0);
      chk("sync_delay_a", {hSync_out, vSync_out}, 2'b01);
      idle();
      chk("sync_delay_b", {hSync_out, vSync_out}, 2'b10);

      for (int i = 0; i < 400; i++) begin
         rx   = (m_lx + $urandom_range(0, 40) + 1020) % 1024;
         ry   = (m_ly + $urandom_range(0, 40) + 508) % 512;
         ract = ($urandom_range(0, 3) != 0);
         rse  = ($urandom_range(0, 15) == 0);
         rpv  = ($urandom_range(0, 3) == 0);
         cyc(rx, ry, ract, 1'($urandom), 1'($urandom), rse, rpv,
             $urandom_range(0, 1023), $urandom_range(0, 511));
      end

      // Asynchronous reset mid-line with a pending position
      while (m_pf) cyc(0, 0, 0, 1, 1, 1, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0, 1, 300, 200);
      repeat (3) cyc(m_lx, m_ly, 1, 0, 0, 0, 0, 0, 0);
      #3 resetn = 1'b0;
      #1;
      chk("async_rgb", {VGA_R, VGA_G, VGA_B}, 12'h000);
      chk("async_hs", hSync_out, 1);
      chk("async_vs", vSync_out, 1);
      chk("async_ready", pos_ready, 1);
      chk("async_rom_addr", rom_addr, 0);
      chk("async_frames", frame_count, 0);
      model_reset();
      @(negedge clk25);
      @(negedge clk25);
      resetn = 1'b1;
      chk("post_rst_ready", pos_ready, 1);
      cyc(64, 400, 1, 1, 1, 0, 0, 0, 0);
      idle();
      idle();
      chk("post_rst_sprite", {VGA_R, VGA_G, VGA_B}, 12'hF00);

      while (m_frames != 16'hFFFF) cyc(0, 0, 0, 1, 1, 1, 0, 0, 0);
      chk("frames_max", frame_count, 16'hFFFF);
      cyc(0, 0, 0, 1, 1, 1, 0, 0, 0);
      chk("frames_wrap", frame_count, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
